// File: rtl/restoring_div16.sv
// restoring_div16: multi-cycle unsigned restoring divider.
// One quotient bit is produced per RUN cycle, and a zero divisor finishes at once.
module restoring_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] a, q, m;
    logic [WIDTH:0]   a_sh, diff;
    logic [CW-1:0]    cnt;
    logic             accept;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (start ? (|divisor ? RUN : FIN) : IDLE) :
              state == RUN  ? (cnt == CW'(1) ? FIN : RUN) : IDLE;
    end

    // The partial remainder always stays below M, so its top bit is only needed transiently in a_sh.
    assign a_sh = {a, q[WIDTH-1]};
    assign diff = a_sh - {1'b0, m};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            m           <= divisor;
            cnt         <= CW'(WIDTH);
            div_by_zero <= ~|divisor;
            a           <= |divisor ? '0 : dividend;
            q           <= |divisor ? dividend : '1;
        end else if (state == RUN) begin
            a   <= diff[WIDTH] ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt - 1'b1;
        end
    end

    assign quotient  = q;
    assign remainder = a;
    assign busy      = state != IDLE;
    assign done      = state == FIN;
endmodule

// File: tb/tb_restoring_div16.sv
// tb_restoring_div16: scoreboard bench; stimulus pushes expected results and done latency,
// and a negedge monitor pops and compares on every done pulse.
module tb_restoring_div16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient, remainder;
    logic        busy, done, div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   pass = 0;
    int   total = 0;

    restoring_div16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
                check("done_latency", cyc, e.due);
                check("busy_at_done", busy, 1);
            end
        end
    end

    // Called just after a negedge; the next posedge accepts. Operands are scrambled afterwards.
    task automatic issue(input logic [15:0] dd, input logic [15:0] dv);
        exp_t e;
        int   k;
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        k = cyc;
        e.q   = dv == 0 ? 16'hFFFF : dd / dv;
        e.r   = dv == 0 ? dd : dd % dv;
        e.dz  = dv == 0;
        e.due = k + (dv == 0 ? 1 : 17);
        sb.push_back(e);
        #1;
        start    = 1'b0;
        dividend = ~dd;
        divisor  = dv + 16'd3;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] dd, input logic [15:0] dv);
        issue(dd, dv);
        wait_done();
    endtask

    initial begin
        #2;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'd100, 16'd7);
        check("busy_after_accept", busy, 1);
        wait_done();
        check("idle_busy", busy, 0);
        check("hold_quotient", quotient, 14);
        check("hold_remainder", remainder, 2);
        run(16'hFFFF, 16'd1);
        run(16'hFFFF, 16'hFFFF);
        run(16'd3, 16'd10);
        run(16'd0, 16'd5);
        run(16'd1234, 16'd0);
        check("dz_held", div_by_zero, 1);
        check("dz_quotient_held", quotient, 16'hFFFF);
        run(16'd1000, 16'd9);
        check("dz_cleared", div_by_zero, 0);

        // A second start mid-run must be ignored along with its operands.
        issue(16'd1000, 16'd9);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);

        // Reset mid-run aborts the operation without a done pulse.
        issue(16'd500, 16'd7);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run(16'd200, 16'd3);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] dd, dv;
            dd = 16'($urandom);
            dv = $urandom_range(0, 3) == 0 ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            run(dd, dv);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
